// File: rtl/spike_packetizer.sv
// spike_packetizer: scans a latched fired-neuron vector in ascending order and emits one
//   router packet {dx, dy, axon} per enabled fired neuron, with out_tick = base_tick + dtick.
// Latency: first packet valid after edge E(k+2), where k is the lowest pending neuron; best case 3 cycles/packet.
// Backpressure: out_valid/out_data/out_tick held until out_ready; fire_ready only high in IDLE.
// Ports: clk/rst (async, active-high); tick; fire_valid/fire_vec/fire_ready;
//   dest_wr_en/addr/data {en,dx,dy,axon,dtick}; out_data/out_tick/out_valid/out_ready;
//   busy, overrun (sticky), sent_count (wrapping).
module spike_packetizer #(
  parameter int NUM_NEURONS = 256,
  parameter int PKT_W       = 26
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           fire_valid,
  input  logic [NUM_NEURONS-1:0]         fire_vec,
  output logic                           fire_ready,
  input  logic                           dest_wr_en,
  input  logic [$clog2(NUM_NEURONS)-1:0] dest_wr_addr,
  input  logic [PKT_W+4:0]               dest_wr_data,
  output logic [PKT_W-1:0]               out_data,
  output logic [3:0]                     out_tick,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           overrun,
  output logic [15:0]                    sent_count
);

  localparam int IDX_W  = $clog2(NUM_NEURONS);
  localparam int DEST_W = PKT_W + 4;  // {dx, dy, axon, dtick} without the enable bit

  typedef enum logic [1:0] {IDLE, SCAN, LOAD, SEND} state_t;

  state_t                   state, state_nxt;
  logic [NUM_NEURONS-1:0]   en;
  logic [NUM_NEURONS-1:0]   pending;
  logic [NUM_NEURONS-1:0]   pend_in;
  logic [IDX_W-1:0]         ptr;
  logic [3:0]               tick_count;
  logic [3:0]               base_tick;
  logic [DEST_W-1:0]        mem [NUM_NEURONS];
  logic [DEST_W-1:0]        rd_q;
  logic                     rd_en;
  logic                     accept;
  logic                     handshake;

  assign fire_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = fire_valid && fire_ready;
  assign pend_in    = fire_vec & en;
  assign rd_en      = (state == SCAN) && pending[ptr];
  assign handshake  = (state == SEND) && out_valid && out_ready;

  // Destination RAM: read-first (a same-address write returns the old entry), no reset.
  always_ff @(posedge clk) begin
    if (dest_wr_en) begin
      mem[dest_wr_addr] <= dest_wr_data[DEST_W-1:0];
    end
    if (rd_en) begin
      rd_q <= mem[ptr];
    end
  end

  // Enable bits live in flops so reset disables every destination at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en <= '0;
    end else if (dest_wr_en) begin
      en[dest_wr_addr] <= dest_wr_data[DEST_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (pend_in != '0)) state_nxt = SCAN;
      SCAN: begin
        if (pending[ptr])          state_nxt = LOAD;
        else if (pending == '0)    state_nxt = IDLE;
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        if (handshake) state_nxt = (pending == '0) ? IDLE : SCAN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      ptr        <= '0;
      base_tick  <= '0;
      tick_count <= '0;
      out_data   <= '0;
      out_tick   <= '0;
      out_valid  <= 1'b0;
      sent_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (tick) begin
        tick_count <= tick_count + 4'd1;
      end
      if (tick && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            pending   <= pend_in;
            base_tick <= tick_count;  // pre-increment value if tick coincides
            ptr       <= '0;
          end
        end
        SCAN: begin
          if (pending[ptr]) begin
            pending[ptr] <= 1'b0;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        LOAD: begin
          out_data  <= rd_q[DEST_W-1:4];
          out_tick  <= base_tick + rd_q[3:0];
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            out_valid  <= 1'b0;
            sent_count <= sent_count + 16'd1;
            // Remaining pending bits are all above ptr, so this cannot overflow.
            if (pending != '0) begin
              ptr <= ptr + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spike_packetizer.md
# spike_packetizer

Egress side of the core's spike path: on each tick the neuron array hands over a 256-bit fired-neuron vector. This block scans it in ascending neuron order and looks up each fired neuron's destination in an internal table. It then emits one 26-bit router packet per fired neuron on a valid/ready stream, which feeds the core's router injection port. The destination table is written through a simple write port driven by the programming interface.

## Interface
Parameters:
- NUM_NEURONS, 256, number of neurons and fire-vector width (index width 8)
- PKT_W, 26, packet width {dx[8:0], dy[8:0], axon[7:0]}

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- tick  in  1  one-cycle 1 kHz sync pulse
- fire_valid  in  1  fire_vec valid
- fire_vec  in  256  bit n = neuron n fired this tick
- fire_ready  out  1  block can accept a vector (high only in IDLE)
- dest_wr_en  in  1  destination table write strobe
- dest_wr_addr  in  8  neuron index
- dest_wr_data  in  31  {en, dx[8:0], dy[8:0], axon[7:0], dtick[3:0]}
- out_data  out  26  packet {dx, dy, axon}; dx and dy are 9-bit two's complement, passed unchanged
- out_tick  out  4  delivery tick sideband
- out_valid  out  1  packet valid
- out_ready  in  1  downstream accepts
- busy  out  1  scan in progress
- overrun  out  1  sticky: a tick arrived while busy
- sent_count  out  16  packets handed off; wraps at 65535→0

## Operation
- Table: 256 entries of dest {dx, dy, axon, dtick}, held in synchronous RAM with read-first behaviour and no reset. There is also a 256-bit en flop array that reset clears. A write updates both.
- tick_count: 4-bit counter, +1 on every tick, wraps 15→0.
- FSM states:
  - IDLE: fire_ready=1. When fire_valid&fire_ready:
    - Latch fire_vec & en into a pending vector; neurons whose en=0 are silently dropped.
    - Latch base_tick = tick_count. If tick is also high in the same cycle, base_tick is the pre-increment value.
    - Set ptr=0.
    - Go to SCAN if the pending vector is nonzero; otherwise stay in IDLE.
  - SCAN: examine pending[ptr].
    - If 0: ptr+1. If the pending vector is now zero, go to IDLE.
    - If 1: issue a RAM read at ptr, clear pending[ptr], go to LOAD.
  - LOAD: register {dx, dy, axon} into out_data and out_tick = (base_tick + dtick) mod 16. Set out_valid=1 and go to SEND.
  - SEND: hold out_data, out_tick and out_valid stable until out_valid&out_ready at an edge. On that edge:
    - out_valid←0 and sent_count+1.
    - If pending is zero, go to IDLE; otherwise ptr+1 and go to SCAN.
- Packets leave in strictly ascending neuron index.
- busy=1 in SCAN, LOAD and SEND.
- overrun: set when tick=1 while busy; cleared only by rst. The current scan continues unaffected.
- Table writes during a scan are allowed. A write and a read to the same address in the same cycle return the old data.

## Timing
- Reset values:
  - fire_ready=1, out_valid=0, out_data=0, out_tick=0, busy=0, overrun=0, sent_count=0.
  - Internal: tick_count=0, en=all 0, FSM=IDLE.
- A reset assertion mid-scan aborts immediately. All pending packets are lost and out_valid drops asynchronously.
- Latency, with the accept edge as E0 and the first pending neuron as k:
  - SCAN with ptr=k occurs in the cycle after E(k).
  - out_valid first becomes high after edge E(k+2).
- Throughput: one packet per 3 cycles at best (SCAN, LOAD, SEND with out_ready=1), plus one cycle per skipped index.
- out_valid never deasserts without a handshake, except on reset.
- fire_valid while busy: not accepted (fire_ready=0). The upstream block must hold the vector.

## Test plan
- Reset check: assert rst mid-SEND. out_valid=0 and fire_ready=1 immediately; sent_count=0; subsequent firing of a previously enabled neuron emits nothing because en was cleared.
- Single spike: write neuron 0 = {en=1, dx=0, dy=0, axon=20, dtick=2} with tick_count=0, then accept fire_vec=1. Require out_valid after E2 with out_data=26'h0000014 and out_tick=2; sent_count=1.
- Ordering and backpressure: write neuron 10 = {1, dx=1, dy=0, axon=30, dtick=2} and neuron 0 as in the single-spike case. Accept bits 0 and 10 with out_ready=0 for 5 cycles. Require out_valid and out_data stable at 0x0000014 for all 5 cycles, then 0x002001E second. Require busy to fall after the second handshake.
- Negative offset and tick wrap: after 15 ticks (tick_count=15), neuron 3 = {1, dx=-1 (9'h1FF), dy=0, axon=8, dtick=3}. Require out_data={9'h1FF, 9'h0, 8'd8}=26'h3FE0008 and out_tick=2.
- Disabled and empty vectors: fire only bit 5 while it is unprogrammed. Require no out_valid, an immediate return to IDLE, and sent_count unchanged. Accepting fire_vec=0 must also produce no packet.
- Overrun: fire 4 enabled neurons with out_ready=0 and pulse tick during SEND. Require overrun=1 (sticky) and fire_ready=0 throughout. After releasing out_ready, require 4 packets, all with out_tick computed from the base_tick latched at accept.
